// File: rtl/keyscan_pkg.sv
// Shared types and constants for the keypad scan path.
// Optional release reporting is selected with the KEYSCAN_RELEASE_EN macro.
package keyscan_pkg;

    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int FIFO_DEPTH = 4;

    // One queued key event: direction flag plus {row, col} key index
    typedef struct packed {
        logic       is_release;
        logic [3:0] code;
    } key_event_t;

    typedef enum logic {
        SCAN  = 1'b0,
        DRAIN = 1'b1
    } scan_state_t;

    // Flat key number from row and column indices
    function automatic logic [3:0] key_index(input logic [1:0] r, input logic [1:0] c);
        return {r, c};
    endfunction

    // Lowest set column in a pending mask; the caller only asks when the mask is non-zero
    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

endpackage

// File: rtl/keyscan_event_fifo.sv
// Four-deep event FIFO; a push into a full FIFO is dropped and flags a sticky overflow,
// unless a pop in the same cycle frees a slot.
module keyscan_event_fifo
    import keyscan_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       push,
    input  key_event_t push_data,
    input  logic       pop,
    input  logic       ovf_clr,
    output key_event_t head,
    output logic       full,
    output logic       empty,
    output logic       ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    key_event_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_pop;
    logic               do_push;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are only observed while the FIFO is non-empty
    always_ff @(posedge HCLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Sticky overflow: a dropped push wins over a simultaneous clear
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)               ovf <= 1'b0;
        else if (push && !do_push)  ovf <= 1'b1;
        else if (ovf_clr)           ovf <= 1'b0;
    end

endmodule

// File: rtl/keypad_scan_driver.sv
// 4x4 keypad row scanner with per-key debounce and a queued event interface.
// Define KEYSCAN_RELEASE_EN to also report key releases.
module keypad_scan_driver
    import keyscan_pkg::*;
#(
    parameter int DWELL     = 1024,
    parameter int DEB_SCANS = 3
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic       ev_valid,
    output logic [3:0] ev_code,
    output logic       ev_release,
    input  logic       ev_ready,
    output logic       key_irq,
    output logic       ovf,
    input  logic       ovf_clr
);

`ifdef KEYSCAN_RELEASE_EN
    localparam logic RELEASE_EN = 1'b1;
`else
    localparam logic RELEASE_EN = 1'b0;
`endif

    logic [3:0]             col_meta;
    logic [3:0]             col_sync;
    logic [15:0]            dwell_cnt;
    logic [1:0]             row_idx;
    logic                   sample;
    logic [ROWS*COLS-1:0]   stable_q;
    logic [1:0]             match_q [ROWS*COLS];
    logic [1:0]             match_nx [COLS];
    logic [3:0]             toggle_mask;
    logic [3:0]             change_mask;
    logic [3:0]             pending_mask;
    logic [1:0]             pend_row;
    scan_state_t            state_q;
    scan_state_t            state_d;
    logic                   drain_en;
    logic [1:0]             drain_col;
    logic [3:0]             drain_clear;
    logic                   push_q;
    key_event_t             push_data_q;
    key_event_t             head;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign sample = (dwell_cnt == 16'(DWELL - 1));
    assign row    = 4'b0001 << row_idx;

    // Two-flop synchronizer for the asynchronous column inputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            col_meta <= '0;
            col_sync <= '0;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    // Dwell counter; the driven row advances when the counter wraps
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dwell_cnt <= '0;
            row_idx   <= '0;
        end else if (sample) begin
            dwell_cnt <= '0;
            row_idx   <= row_idx + 1'b1;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    // Debounce decision for the four keys of the currently driven row
    always_comb begin
        toggle_mask = '0;
        change_mask = '0;
        for (int c = 0; c < COLS; c++) begin
            match_nx[c] = '0;
            if (col_sync[c] != stable_q[key_index(row_idx, 2'(c))]) begin
                if (({1'b0, match_q[key_index(row_idx, 2'(c))]} + 3'd1) == 3'(DEB_SCANS)) begin
                    toggle_mask[c] = 1'b1;
                    change_mask[c] = RELEASE_EN | col_sync[c];
                end else begin
                    match_nx[c] = match_q[key_index(row_idx, 2'(c))] + 2'd1;
                end
            end
        end
    end

    // Per-key stable state and match counters, updated only at the sample point
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stable_q <= '0;
            for (int k = 0; k < ROWS*COLS; k++) match_q[k] <= '0;
        end else if (sample) begin
            for (int c = 0; c < COLS; c++) begin
                stable_q[key_index(row_idx, 2'(c))] <= stable_q[key_index(row_idx, 2'(c))] ^ toggle_mask[c];
                match_q[key_index(row_idx, 2'(c))]  <= match_nx[c];
            end
        end
    end

    // Drain FSM state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= SCAN;
        else          state_q <= state_d;
    end

    // Drain FSM next state: stay in DRAIN until the last pending column is taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN:    if (sample && (change_mask != '0)) state_d = DRAIN;
            DRAIN: begin
                if (sample && (change_mask != '0))               state_d = DRAIN;
                else if ((pending_mask & ~drain_clear) == '0)   state_d = SCAN;
            end
            default: state_d = SCAN;
        endcase
    end

    // Drain FSM outputs: one pending column per cycle, lowest first
    always_comb begin
        drain_en    = (state_q == DRAIN);
        drain_col   = lowest_set(pending_mask);
        drain_clear = drain_en ? (4'b0001 << drain_col) : 4'b0000;
    end

    // Pending columns of the row just sampled
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pending_mask <= '0;
            pend_row     <= '0;
        end else if (sample) begin
            pending_mask <= change_mask;
            pend_row     <= row_idx;
        end else begin
            pending_mask <= pending_mask & ~drain_clear;
        end
    end

    // Registered push stage between the drain and the FIFO write
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            push_q                 <= drain_en;
            push_data_q.code       <= key_index(pend_row, drain_col);
            push_data_q.is_release <= RELEASE_EN & ~stable_q[key_index(pend_row, drain_col)];
        end
    end

    keyscan_event_fifo u_fifo (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (ev_valid && ev_ready),
        .ovf_clr   (ovf_clr),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .ovf       (ovf)
    );

    assign ev_valid   = !fifo_empty;
    assign key_irq    = ev_valid;
    assign ev_code    = fifo_empty ? 4'd0 : head.code;
    assign ev_release = RELEASE_EN & ev_valid & head.is_release;

endmodule
